// File: rtl/pulse_stretch.sv
// Stretches single-cycle event pulses into level outputs of fixed width with a minimum low gap.
// Events arriving mid-period are queued (saturating) or, with RETRIGGER, extend the high period.
module pulse_stretch #(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_PENDING = 3,
  parameter bit          RETRIGGER   = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pulse_in,
  output logic                             level_out,
  output logic                             busy,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic                             overflow
);

  localparam int unsigned PendW  = $clog2(MAX_PENDING + 1);
  localparam int unsigned CntMax = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]  HighLd  = CntW'(HIGH_CYCLES);
  localparam logic [CntW-1:0]  GapLd   = CntW'(GAP_CYCLES);
  localparam logic [PendW-1:0] PendMax = PendW'(MAX_PENDING);

  typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PendW-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             level_q, busy_q;
  logic             expire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    expire  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pulse_in) begin
          state_d = StHigh;
          cnt_d   = HighLd;
        end
      end
      StHigh: begin
        if (cnt_q == CntW'(1)) begin
          if (GAP_CYCLES == 0) begin
            expire = 1'b1;
          end else begin
            state_d = StGap;
            cnt_d   = GapLd;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(1)) expire = 1'b1;
        else                   cnt_d  = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase

    // At expiry a live pulse is served directly; otherwise one queued event is consumed.
    if (expire) begin
      if ((pend_q != '0) || pulse_in) begin
        state_d = StHigh;
        cnt_d   = HighLd;
        if (!pulse_in) pend_d = pend_q - PendW'(1);
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else if (pulse_in && (state_q != StIdle)) begin
      if (RETRIGGER && (state_q == StHigh)) begin
        state_d = StHigh;
        cnt_d   = HighLd;
      end else if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PendW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= (state_d == StHigh);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: queueing instance (u0) and retrigger instance (u1).
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse;
  logic       lvl0, busy0, ovf0, lvl1, busy1, ovf1;
  logic [1:0] pend0, pend1;
  int         total = 0;
  int         bad   = 0;
  int         rises;
  logic       prev;

  always #5 clk = ~clk;

  pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .MAX_PENDING(3), .RETRIGGER(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse),
    .level_out(lvl0), .busy(busy0), .pending(pend0), .overflow(ovf0)
  );

  pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .MAX_PENDING(3), .RETRIGGER(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse),
    .level_out(lvl1), .busy(busy1), .pending(pend1), .overflow(ovf1)
  );

  function automatic logic rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d got=%0d want=%0d", tag, c, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pulse = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Each loop iteration: at the negedge of cycle c, check outputs, then drive pulse for cycle c.
  initial begin
    rst_n = 1'b0;
    pulse = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", 0, 8'(lvl0), 8'(0));
    chk("rst_busy", 0, 8'(busy0), 8'(0));
    chk("rst_pend", 0, 8'(pend0), 8'(0));
    chk("rst_ovf", 0, 8'(ovf0), 8'(0));
    chk("rst_level_r", 0, 8'(lvl1), 8'(0));
    chk("rst_busy_r", 0, 8'(busy1), 8'(0));
    rst_n = 1'b1;

    // Single pulse
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("single_level", c, 8'(lvl0), 8'(rng(c, 1, 4)));
      chk("single_busy", c, 8'(busy0), 8'(rng(c, 1, 6)));
      chk("single_pend", c, 8'(pend0), 8'(0));
      pulse = (c == 0);
    end

    // Pulses at 0,1,2 queue two events
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("queue_level", c, 8'(lvl0), 8'(rng(c, 1, 4) || rng(c, 7, 10) || rng(c, 13, 16)));
      chk("queue_pend", c, 8'(pend0),
          (c < 2) ? 8'(0) : (c == 2) ? 8'(1) : (c <= 6) ? 8'(2) : (c <= 12) ? 8'(1) : 8'(0));
      chk("queue_busy", c, 8'(busy0), 8'(rng(c, 1, 18)));
      pulse = (c <= 2);
    end

    // Pulse held for cycles 0..5: saturation and overflow
    do_reset();
    rises = 0;
    prev  = 1'b0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (lvl0 && !prev) rises++;
      prev = lvl0;
      chk("sat_pend", c, 8'(pend0),
          (c < 2) ? 8'(0) : (c == 2) ? 8'(1) : (c == 3) ? 8'(2) :
          (c <= 6) ? 8'(3) : (c <= 12) ? 8'(2) : (c <= 18) ? 8'(1) : 8'(0));
      if (c <= 4) chk("sat_ovf_lo", c, 8'(ovf0), 8'(0));
      if (c >= 6) chk("sat_ovf_hi", c, 8'(ovf0), 8'(1));
      chk("sat_level", c, 8'(lvl0),
          8'(rng(c, 1, 4) || rng(c, 7, 10) || rng(c, 13, 16) || rng(c, 19, 22)));
      pulse = (c <= 5);
    end
    chk("sat_periods", 26, 8'(rises), 8'(4));
    chk("sat_idle", 26, 8'(busy0), 8'(0));

    // Retrigger instance: pulses at 0 and 3 extend the high period
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("retrig_level", c, 8'(lvl1), 8'(rng(c, 1, 7)));
      chk("retrig_busy", c, 8'(busy1), 8'(rng(c, 1, 9)));
      chk("retrig_pend", c, 8'(pend1), 8'(0));
      pulse = (c == 0) || (c == 3);
    end

    // Reset mid-operation, then a fresh single pulse at cycle 4
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c < 3) begin
        chk("abort_pre_level", c, 8'(lvl0), 8'(rng(c, 1, 2)));
      end else begin
        chk("abort_level", c, 8'(lvl0), 8'(rng(c, 5, 8)));
        chk("abort_busy", c, 8'(busy0), 8'(rng(c, 5, 10)));
        chk("abort_pend", c, 8'(pend0), 8'(0));
      end
      rst_n = (c != 2);
      pulse = (c <= 1) || (c == 4);
    end

    // Pulse on the final gap cycle re-enters HIGH with no idle cycle
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("gap_level", c, 8'(lvl0), 8'(rng(c, 1, 4) || rng(c, 7, 10)));
      chk("gap_busy", c, 8'(busy0), 8'(rng(c, 1, 12)));
      chk("gap_pend", c, 8'(pend0), 8'(0));
      pulse = (c == 0) || (c == 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
